// File: rtl/matrix_pkg.sv
// Shared constants and FSM state encoding for the matrix transpose engine.
package matrix_pkg;

  localparam int XP_DATA_W  = 32;
  localparam int XP_ADDR_W  = 8;
  localparam int XP_DIM_W   = 3;
  localparam int XP_MAX_DIM = 5;

  typedef enum logic [2:0] {
    XP_IDLE  = 3'd0,
    XP_CHECK = 3'd1,
    XP_RD    = 3'd2,
    XP_WR    = 3'd3,
    XP_DONE  = 3'd4
  } xp_state_e;

endpackage

// File: rtl/xpose_addr_gen.sv
// Row-major source walk with transposed destination pointer, built from
// counters only: dst advances by m per column and restarts at dst+r+1 per row.
module xpose_addr_gen
  import matrix_pkg::*;
#(
  parameter int ADDR_W = XP_ADDR_W,
  parameter int DIM_W  = XP_DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [DIM_W-1:0]  m_i,
  input  logic [DIM_W-1:0]  n_i,
  output logic [ADDR_W-1:0] src_ptr_o,
  output logic [ADDR_W-1:0] dst_ptr_o,
  output logic              last_elem_o
);

  logic [DIM_W-1:0]  r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      c_q   <= '0;
      src_q <= '0;
      dst_q <= '0;
    end else begin
      r_q   <= r_d;
      c_q   <= c_d;
      src_q <= src_d;
      dst_q <= dst_d;
    end
  end

  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    src_d = src_q;
    dst_d = dst_q;
    if (load_i) begin
      r_d   = '0;
      c_d   = '0;
      src_d = src_i;
      dst_d = dst_i;
    end else if (step_i) begin
      src_d = src_q + ADDR_W'(1);
      if (c_q == n_i - DIM_W'(1)) begin
        c_d   = '0;
        r_d   = r_q + DIM_W'(1);
        dst_d = dst_i + ADDR_W'(r_q) + ADDR_W'(1);
      end else begin
        c_d   = c_q + DIM_W'(1);
        dst_d = dst_q + ADDR_W'(m_i);
      end
    end else begin
      r_d = r_q;
    end
  end

  assign src_ptr_o   = src_q;
  assign dst_ptr_o   = dst_q;
  assign last_elem_o = (r_q == m_i - DIM_W'(1)) && (c_q == n_i - DIM_W'(1));

endmodule

// File: rtl/matrix_transpose_engine.sv
// Transposes an m x n row-major matrix from src to dst via one single-port storage.
// Optional macro XPOSE_CHECKSUM_EN adds o_checksum, the wrapping sum of written data.
module matrix_transpose_engine
  import matrix_pkg::*;
#(
  parameter int DATA_W  = XP_DATA_W,
  parameter int ADDR_W  = XP_ADDR_W,
  parameter int DIM_W   = XP_DIM_W,
  parameter int MAX_DIM = XP_MAX_DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [DIM_W-1:0]  i_m,
  input  logic [DIM_W-1:0]  i_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
`ifdef XPOSE_CHECKSUM_EN
  output logic [DATA_W+2*DIM_W-1:0] o_checksum,
`endif
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int SUM_W  = ADDR_W + 1;
  localparam int PROD_W = 2 * DIM_W;

  xp_state_e         state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [DIM_W-1:0]  m_q, n_q;
  logic              err_q, err_d;
  logic              accept_s, load_s, step_s, last_s, check_fail_s;
  logic [ADDR_W-1:0] src_ptr_s, dst_ptr_s;
  logic [PROD_W-1:0] prod_s;
  logic [SUM_W-1:0]  mn_s, src_end_s, dst_end_s, limit_s;

  assign accept_s = (state_q == XP_IDLE) && i_start;
  assign load_s   = (state_q == XP_CHECK);
  assign step_s   = (state_q == XP_WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= XP_IDLE;
      err_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept_s) begin
        src_q <= i_src_addr;
        dst_q <= i_dst_addr;
        m_q   <= i_m;
        n_q   <= i_n;
      end
    end
  end

  // Address sums carry one extra bit so an end address of exactly 2^ADDR_W is legal
  // while anything past it is caught.
  assign prod_s    = PROD_W'(m_q) * PROD_W'(n_q);
  assign mn_s      = SUM_W'(prod_s);
  assign src_end_s = {1'b0, src_q} + mn_s;
  assign dst_end_s = {1'b0, dst_q} + mn_s;
  assign limit_s   = {1'b1, {ADDR_W{1'b0}}};
  assign check_fail_s = (m_q == '0) || (n_q == '0)
                     || (m_q > DIM_W'(MAX_DIM)) || (n_q > DIM_W'(MAX_DIM))
                     || (src_end_s > limit_s) || (dst_end_s > limit_s)
                     || (({1'b0, src_q} < dst_end_s) && ({1'b0, dst_q} < src_end_s));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      XP_IDLE: begin
        if (i_start) begin
          state_d = XP_CHECK;
          err_d   = 1'b0;
        end else begin
          state_d = XP_IDLE;
        end
      end
      XP_CHECK: begin
        if (check_fail_s) begin
          state_d = XP_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = XP_RD;
        end
      end
      XP_RD:   state_d = XP_WR;
      XP_WR:   state_d = last_s ? XP_DONE : XP_RD;
      XP_DONE: state_d = XP_IDLE;
      default: state_d = XP_IDLE;
    endcase
  end

  xpose_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_s),
    .step_i      (step_s),
    .src_i       (src_q),
    .dst_i       (dst_q),
    .m_i         (m_q),
    .n_i         (n_q),
    .src_ptr_o   (src_ptr_s),
    .dst_ptr_o   (dst_ptr_s),
    .last_elem_o (last_s)
  );

  always_comb begin
    o_mem_addr = '0;
    case (state_q)
      XP_RD:   o_mem_addr = src_ptr_s;
      XP_WR:   o_mem_addr = dst_ptr_s;
      default: o_mem_addr = '0;
    endcase
  end

  assign o_busy      = (state_q == XP_CHECK) || (state_q == XP_RD) || (state_q == XP_WR);
  assign o_done      = (state_q == XP_DONE);
  assign o_err       = err_q;
  assign o_mem_we    = step_s;
  assign o_mem_wdata = i_mem_rdata;

`ifdef XPOSE_CHECKSUM_EN
  logic [DATA_W+2*DIM_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (accept_s) begin
      checksum_q <= '0;
    end else if (step_s) begin
      checksum_q <= checksum_q + (DATA_W+2*DIM_W)'(i_mem_rdata);
    end
  end

  assign o_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_matrix_transpose_engine.sv
// Directed bench for matrix_transpose_engine with a 1-cycle-latency storage model.
module tb_matrix_transpose_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_src_addr = 8'd0;
  logic [7:0]  i_dst_addr = 8'd0;
  logic [2:0]  i_m = 3'd0;
  logic [2:0]  i_n = 3'd0;
  logic        o_busy, o_done, o_err, o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = 32'd0;
`ifdef XPOSE_CHECKSUM_EN
  logic [37:0] o_checksum;
`endif

  logic [31:0] mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_addr = 8'd0;
  logic [31:0] tb_wdata = 32'd0;

  int checks = 0;
  int passed = 0;

  matrix_transpose_engine dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_src_addr  (i_src_addr),
    .i_dst_addr  (i_dst_addr),
    .i_m         (i_m),
    .i_n         (i_n),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
`ifdef XPOSE_CHECKSUM_EN
    .o_checksum  (o_checksum),
`endif
    .o_mem_addr  (o_mem_addr),
    .o_mem_we    (o_mem_we),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Starts an operation and samples at each falling edge; cycle 1 is the CHECK cycle.
  task automatic run_op(input logic [7:0] src, input logic [7:0] dst,
                        input logic [2:0] m, input logic [2:0] n, input int repulse_at,
                        output int done_cyc, output int nwr, output int ndone,
                        output logic err_c1, output logic err_done, output logic busy_done);
    done_cyc = -1; nwr = 0; ndone = 0; err_c1 = 1'bx; err_done = 1'bx; busy_done = 1'bx;
    @(negedge clk);
    i_start = 1'b1; i_src_addr = src; i_dst_addr = dst; i_m = m; i_n = n;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      if (o_mem_we) nwr++;
      if (cyc == 1) err_c1 = o_err;
      if (o_done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc; err_done = o_err; busy_done = o_busy;
        end
      end
      if (cyc == 1) begin
        i_start = 1'b0; i_src_addr = 8'hAA; i_dst_addr = 8'h00; i_m = 3'd7; i_n = 3'd7;
      end
      if (cyc == repulse_at) i_start = 1'b1;
      if (cyc == repulse_at + 1) i_start = 1'b0;
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else passed++;
    checks++; if (o_done !== 1'b0) $display("FAIL reset_done got %b want 0", o_done); else passed++;
    checks++; if (o_err !== 1'b0) $display("FAIL reset_err got %b want 0", o_err); else passed++;
    checks++; if (o_mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", o_mem_we); else passed++;
    checks++; if (o_mem_addr !== 8'd0) $display("FAIL reset_addr got %0d want 0", o_mem_addr); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_2x3;
    int dc, nw, nd;
    logic e1, ed, bd;
    logic [31:0] exp_v [6];
    exp_v = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
    for (int i = 0; i < 6; i++) poke(8'(i), 32'(i + 1));
    for (int i = 0; i < 6; i++) poke(8'(12 + i), 32'd0);
    run_op(8'd0, 8'd12, 3'd2, 3'd3, -10, dc, nw, nd, e1, ed, bd);
    checks++; if (dc !== 14) $display("FAIL t2x3_latency got %0d want 14", dc); else passed++;
    checks++; if (ed !== 1'b0) $display("FAIL t2x3_err got %b want 0", ed); else passed++;
    checks++; if (bd !== 1'b0) $display("FAIL t2x3_busy_at_done got %b want 0", bd); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem[12 + i] !== exp_v[i]) $display("FAIL t2x3_mem[%0d] got %0d want %0d", 12 + i, mem[12 + i], exp_v[i]);
      else passed++;
    end
`ifdef XPOSE_CHECKSUM_EN
    checks++; if (o_checksum !== 38'd21) $display("FAIL t2x3_checksum got %0d want 21", o_checksum); else passed++;
`endif
  endtask

  task automatic test_1x1;
    int dc, nw, nd;
    logic e1, ed, bd;
    poke(8'd0, 32'd9);
    poke(8'd1, 32'd0);
    run_op(8'd0, 8'd1, 3'd1, 3'd1, -10, dc, nw, nd, e1, ed, bd);
    checks++; if (dc !== 4) $display("FAIL t1x1_latency got %0d want 4", dc); else passed++;
    checks++; if (ed !== 1'b0) $display("FAIL t1x1_err got %b want 0", ed); else passed++;
    checks++; if (mem[1] !== 32'd9) $display("FAIL t1x1_mem1 got %0d want 9", mem[1]); else passed++;
  endtask

  task automatic test_errors;
    int dc, nw, nd;
    logic e1, ed, bd;
    logic [7:0] srcs [4], dsts [4];
    logic [2:0] ms [4], ns [4];
    srcs = '{8'd0, 8'd0, 8'd0, 8'd0};
    dsts = '{8'd20, 8'd20, 8'd3, 8'd252};
    ms   = '{3'd0, 3'd6, 3'd2, 3'd2};
    ns   = '{3'd3, 3'd1, 3'd3, 3'd3};
    for (int k = 0; k < 4; k++) begin
      run_op(srcs[k], dsts[k], ms[k], ns[k], -10, dc, nw, nd, e1, ed, bd);
      checks++; if (dc !== 2) $display("FAIL err%0d_latency got %0d want 2", k, dc); else passed++;
      checks++; if (ed !== 1'b1) $display("FAIL err%0d_err got %b want 1", k, ed); else passed++;
      checks++; if (nw !== 0) $display("FAIL err%0d_writes got %0d want 0", k, nw); else passed++;
    end
    checks++; if (o_err !== 1'b1) $display("FAIL err_sticky got %b want 1", o_err); else passed++;
  endtask

  task automatic test_boundary;
    int dc, nw, nd;
    logic e1, ed, bd;
    for (int i = 0; i < 6; i++) poke(8'(i), 32'(i + 1));
    run_op(8'd0, 8'd250, 3'd2, 3'd3, -10, dc, nw, nd, e1, ed, bd);
    checks++; if (e1 !== 1'b0) $display("FAIL bnd_err_cleared got %b want 0", e1); else passed++;
    checks++; if (dc !== 14) $display("FAIL bnd_latency got %0d want 14", dc); else passed++;
    checks++; if (ed !== 1'b0) $display("FAIL bnd_err got %b want 0", ed); else passed++;
    checks++; if (mem[250] !== 32'd1) $display("FAIL bnd_mem250 got %0d want 1", mem[250]); else passed++;
    checks++; if (mem[255] !== 32'd6) $display("FAIL bnd_mem255 got %0d want 6", mem[255]); else passed++;
  endtask

  task automatic test_restart_ignored;
    int dc, nw, nd;
    logic e1, ed, bd;
    for (int i = 0; i < 9; i++) poke(8'(i), 32'(i + 1));
    run_op(8'd0, 8'd20, 3'd3, 3'd3, 5, dc, nw, nd, e1, ed, bd);
    checks++; if (dc !== 20) $display("FAIL rs_latency got %0d want 20", dc); else passed++;
    checks++; if (nd !== 1) $display("FAIL rs_done_count got %0d want 1", nd); else passed++;
    checks++; if (nw !== 9) $display("FAIL rs_writes got %0d want 9", nw); else passed++;
    checks++; if (mem[21] !== 32'd4) $display("FAIL rs_mem21 got %0d want 4", mem[21]); else passed++;
    checks++; if (mem[28] !== 32'd9) $display("FAIL rs_mem28 got %0d want 9", mem[28]); else passed++;
  endtask

  task automatic test_reset_mid_op;
    poke(8'd40, 32'd0);
    @(negedge clk);
    i_start = 1'b1; i_src_addr = 8'd0; i_dst_addr = 8'd40; i_m = 3'd3; i_n = 3'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (o_mem_we !== 1'b0) $display("FAIL rmid_we got %b want 0", o_mem_we); else passed++;
    checks++; if (o_busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", o_busy); else passed++;
    checks++; if (o_done !== 1'b0) $display("FAIL rmid_done got %b want 0", o_done); else passed++;
    checks++; if (o_mem_addr !== 8'd0) $display("FAIL rmid_addr got %0d want 0", o_mem_addr); else passed++;
    checks++; if (mem[40] !== 32'd1) $display("FAIL rmid_partial got %0d want 1", mem[40]); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) $display("FAIL rmid_stays_idle got %b want 0", o_busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_2x3();
    test_1x1();
    test_errors();
    test_boundary();
    test_restart_ignored();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
